// File: rtl/alu_issue_stage_pkg.sv
// Shared op definitions for the ALU issue stage: ALU operation codes,
// operand-source encodings and forward-select codes.
package alu_issue_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDU = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBU = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOR  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_SLL  = 4'd10,
    OP_SRL  = 4'd11,
    OP_SRA  = 4'd12,
    OP_LUI  = 4'd13
  } aluop_e;

  localparam logic ASEL_RS    = 1'b0;
  localparam logic ASEL_SHAMT = 1'b1;
  localparam logic BSEL_RT    = 1'b0;
  localparam logic BSEL_IMM   = 1'b1;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // Shift amount presented as a full-width A operand.
  function automatic logic [DATA_W-1:0] shamt_ext(input logic [REG_W-1:0] shamt);
    return {{(DATA_W-REG_W){1'b0}}, shamt};
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_unit.sv
// Operand forwarding for one source register. Purely combinational.
// With ALU_FWD_EN defined the youngest in-flight writer (MEM, then WB)
// supplies the value; without it the registered data passes straight through.
module fwd_unit
  import alu_issue_stage_pkg::*;
(
  input  logic [4:0]  src_addr,
  input  logic [31:0] reg_data,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_result,
  output logic [1:0]  sel,
  output logic [31:0] value
);

`ifdef ALU_FWD_EN
  // MEM is younger than WB so it wins; r0 is hard-wired and never forwarded.
  always_comb begin
    sel   = FWD_REG;
    value = reg_data;
    if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == src_addr)) begin
      sel   = FWD_MEM;
      value = mem_result;
    end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == src_addr)) begin
      sel   = FWD_WB;
      value = wb_result;
    end
  end
`else
  logic unused_fwd;

  assign sel        = FWD_REG;
  assign value      = reg_data;
  assign unused_fwd = ^{src_addr, mem_reg_write, mem_rd_addr, mem_result,
                        wb_reg_write, wb_rd_addr, wb_result};
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: captures decoded instructions, resolves operands by
// forwarding from MEM/WB, inserts bubbles on hazards and drives the ALU.
// Build option: ALU_FWD_EN enables MEM/WB forwarding and load-only hazard
// detection; without it the stage interlocks on any in-flight writer.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [3:0]  id_aluop,
  input  logic        id_asel,
  input  logic        id_bsel,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_result,
  output logic        id_stall,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        ex_valid,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [31:0] ex_store_data
);

  logic        vld_p0;
  logic [4:0]  rs_addr_p0;
  logic [4:0]  rt_addr_p0;
  logic        use_rs_p0;
  logic        use_rt_p0;
  logic [31:0] rs_data_p0;
  logic [31:0] rt_data_p0;
  logic [31:0] imm_p0;
  logic [4:0]  shamt_p0;
  logic [3:0]  aluop_p0;
  logic        asel_p0;
  logic        bsel_p0;
  logic [4:0]  rd_p0;
  logic        rw_p0;
  logic        mr_p0;

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic [1:0]  rs_sel;
  logic [1:0]  rt_sel;
  logic        hazard;
  logic        unused_ex;

  // True when a nonzero destination feeds a source the ID instruction reads.
  function automatic logic reads_reg(input logic [4:0] rd,
                                     input logic use_rs, input logic [4:0] rs,
                                     input logic use_rt, input logic [4:0] rt);
    return (rd != 5'd0) && ((use_rs && (rd == rs)) || (use_rt && (rd == rt)));
  endfunction

  fwd_unit u_fwd_rs (
    .src_addr      (rs_addr_p0),
    .reg_data      (rs_data_p0),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .sel           (rs_sel),
    .value         (fwd_rs)
  );

  fwd_unit u_fwd_rt (
    .src_addr      (rt_addr_p0),
    .reg_data      (rt_data_p0),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .sel           (rt_sel),
    .value         (fwd_rt)
  );

`ifdef ALU_FWD_EN
  // Only a load in EX cannot be forwarded in time for the next instruction.
  assign hazard = id_valid & vld_p0 & mr_p0 & rw_p0 &
                  reads_reg(rd_p0, id_use_rs, id_rs_addr, id_use_rt, id_rt_addr);
`else
  // Without forwarding any writer still in EX or MEM must retire first;
  // WB is visible through the write-first register file.
  assign hazard = id_valid &
                  ((vld_p0 & rw_p0 &
                    reads_reg(rd_p0, id_use_rs, id_rs_addr, id_use_rt, id_rt_addr)) |
                   (mem_reg_write &
                    reads_reg(mem_rd_addr, id_use_rs, id_rs_addr, id_use_rt, id_rt_addr)));
`endif

  assign id_stall = hazard | ex_stall;

  // ---- ID -> EX boundary ----
  // EX register: hold (with operand refresh) on stall, else capture ID,
  // turning the slot into a bubble on flush or hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      rs_addr_p0 <= '0;
      rt_addr_p0 <= '0;
      use_rs_p0  <= 1'b0;
      use_rt_p0  <= 1'b0;
      rs_data_p0 <= '0;
      rt_data_p0 <= '0;
      imm_p0     <= '0;
      shamt_p0   <= '0;
      aluop_p0   <= '0;
      asel_p0    <= 1'b0;
      bsel_p0    <= 1'b0;
      rd_p0      <= '0;
      rw_p0      <= 1'b0;
      mr_p0      <= 1'b0;
    end else if (ex_stall) begin
      // Refresh keeps forwarded values once their producers retire.
      rs_data_p0 <= fwd_rs;
      rt_data_p0 <= fwd_rt;
    end else begin
      rs_addr_p0 <= id_rs_addr;
      rt_addr_p0 <= id_rt_addr;
      use_rs_p0  <= id_use_rs;
      use_rt_p0  <= id_use_rt;
      rs_data_p0 <= id_rs_data;
      rt_data_p0 <= id_rt_data;
      imm_p0     <= id_imm;
      shamt_p0   <= id_shamt;
      aluop_p0   <= id_aluop;
      asel_p0    <= id_asel;
      bsel_p0    <= id_bsel;
      rd_p0      <= id_rd_addr;
      if (flush || hazard) begin
        vld_p0 <= 1'b0;
        rw_p0  <= 1'b0;
        mr_p0  <= 1'b0;
      end else begin
        vld_p0 <= id_valid;
        rw_p0  <= id_valid & id_reg_write;
        mr_p0  <= id_valid & id_mem_read;
      end
    end
  end

  // ---- EX -> ALU / MEM boundary ----
  assign alu_a         = (asel_p0 == ASEL_SHAMT) ? shamt_ext(shamt_p0) : fwd_rs;
  assign alu_b         = (bsel_p0 == BSEL_IMM) ? imm_p0 : fwd_rt;
  assign alu_op        = aluop_p0;
  assign ex_valid      = vld_p0;
  assign ex_rd_addr    = rd_p0;
  assign ex_reg_write  = vld_p0 & rw_p0;
  assign ex_mem_read   = vld_p0 & mr_p0;
  assign ex_store_data = fwd_rt;

  // Source-use flags and select codes are kept for debug visibility only.
  assign unused_ex = ^{use_rs_p0, use_rt_p0, rs_sel, rt_sel};

endmodule
